// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the ethernet reset sequencer: state encoding and
// the SIM_FAST effective-delay helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        LOCK_WAIT = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Simulation builds collapse every programmable wait to a single cycle.
    function automatic int unsigned eff_cycles(input int unsigned cycles, input bit sim_fast);
        return sim_fast ? 32'd1 : cycles;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// PLL lock debounce: pulses once when pll_lock_i has been high for
// LOCK_FILTER consecutive enabled samples.
module lock_filter #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned LOCK_FILTER = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable_i,
    input  logic pll_lock_i,
    output logic locked_pulse_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_FILTER - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational pulse so the owner can change state on the Nth high edge.
    always_comb begin
        locked_pulse_o = enable_i && pll_lock_i && (cnt_q == LAST);
        cnt_d          = cnt_q + CNT_W'(1);
        if (!enable_i || !pll_lock_i || locked_pulse_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the ethernet subsystem; re-sequences on PLL lock
// loss or software request.  States: HOLD | in reset, LOCK_WAIT | filtering
// lock, RELEASE | stepping stages out, RUN | all stages released.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned             NUM_STAGES  = 2,
    parameter int unsigned             CNT_W       = 20,
    parameter int unsigned             STAGE_DELAY = 20'h10000,
    parameter int unsigned             LOCK_FILTER = 256,
    parameter logic [NUM_STAGES-1:0]   ACTIVE_LOW  = NUM_STAGES'(2'b01),
    parameter bit                      SIM_FAST    = 1'b0,
    localparam int unsigned            IDX_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pll_lock_i,
    input  logic                  sw_rst_i,
    input  logic                  lock_lost_clr_i,
    output logic [NUM_STAGES-1:0] rst_out_o,
    output logic [IDX_W-1:0]      stage_idx_o,
    output logic                  seq_done_o,
    output logic                  lock_lost_o
);

    localparam int unsigned      DLY_EFF  = eff_cycles(STAGE_DELAY, SIM_FAST);
    localparam int unsigned      FILT_EFF = eff_cycles(LOCK_FILTER, SIM_FAST);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_EFF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
        $error("reset_sequencer: NUM_STAGES must be 1..8");
    end
    if (STAGE_DELAY == 0 || LOCK_FILTER == 0 ||
        64'(STAGE_DELAY) >= (64'd1 << CNT_W) ||
        64'(LOCK_FILTER) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W too narrow for STAGE_DELAY/LOCK_FILTER");
    end

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  done_q, done_d;
    logic                  lost_q, lost_d;
    logic                  filt_en;
    logic                  locked_pulse;

    assign filt_en = (state_q == LOCK_WAIT) && !sw_rst_i;

    lock_filter #(
        .CNT_W       (CNT_W),
        .LOCK_FILTER (FILT_EFF)
    ) u_lock_filter (
        .clk            (clk),
        .rstn           (rstn),
        .enable_i       (filt_en),
        .pll_lock_i     (pll_lock_i),
        .locked_pulse_o (locked_pulse)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        lost_d  = lost_q & ~lock_lost_clr_i;

        case (state_q)
            HOLD: begin
                state_d = LOCK_WAIT;
                cnt_d   = '0;
                idx_d   = '0;
                done_d  = 1'b0;
            end
            LOCK_WAIT: begin
                if (locked_pulse) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE, RUN: begin
                if (!pll_lock_i || sw_rst_i) begin
                    state_d = LOCK_WAIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    if (!pll_lock_i) begin
                        lost_d = 1'b1;
                    end
                end else if (state_q == RELEASE) begin
                    if (cnt_q == DLY_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = HOLD;
        endcase

        // Stages below the next index are released; the rest stay asserted.
        rst_d = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            rst_d[k] = (IDX_W'(k) < idx_d) ? ACTIVE_LOW[k] : ~ACTIVE_LOW[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= ~ACTIVE_LOW;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign rst_out_o   = rst_q;
    assign stage_idx_o = idx_q;
    assign seq_done_o  = done_q;
    assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 2-stage instance with short delays
// and a 4-stage SIM_FAST instance with mixed polarity.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rstn_f = 1'b0;
    logic       pll_lock = 1'b0;
    logic       sw_rst = 1'b0;
    logic       lock_lost_clr = 1'b0;

    logic [1:0] rst_out;
    logic [1:0] stage_idx;
    logic       seq_done;
    logic       lock_lost;

    logic [3:0] rst_out_f;
    logic [2:0] stage_idx_f;
    logic       seq_done_f;
    logic       lock_lost_f;

    int errors = 0;
    int checks = 0;

    logic [5:0] obs;
    logic [8:0] obs_f;
    assign obs   = {rst_out, stage_idx, seq_done, lock_lost};
    assign obs_f = {rst_out_f, stage_idx_f, seq_done_f, lock_lost_f};

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES  (2),
        .CNT_W       (20),
        .STAGE_DELAY (8),
        .LOCK_FILTER (4),
        .ACTIVE_LOW  (2'b01),
        .SIM_FAST    (1'b0)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .pll_lock_i      (pll_lock),
        .sw_rst_i        (sw_rst),
        .lock_lost_clr_i (lock_lost_clr),
        .rst_out_o       (rst_out),
        .stage_idx_o     (stage_idx),
        .seq_done_o      (seq_done),
        .lock_lost_o     (lock_lost)
    );

    reset_sequencer #(
        .NUM_STAGES (4),
        .ACTIVE_LOW (4'b1010),
        .SIM_FAST   (1'b1)
    ) dut_f (
        .clk             (clk),
        .rstn            (rstn_f),
        .pll_lock_i      (pll_lock),
        .sw_rst_i        (sw_rst),
        .lock_lost_clr_i (lock_lost_clr),
        .rst_out_o       (rst_out_f),
        .stage_idx_o     (stage_idx_f),
        .seq_done_o      (seq_done_f),
        .lock_lost_o     (lock_lost_f)
    );

    // Advance n rising edges; inputs and samples sit 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // obs fields: {rst_out[1:0], stage_idx[1:0], seq_done, lock_lost}
    task automatic test_reset();
        rstn = 1'b0; rstn_f = 1'b0; pll_lock = 1'b1;
        step(3);
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL reset_a got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        checks++;
        if (obs_f !== 9'b0101_000_0_0) begin
            errors++; $display("FAIL reset_fast got=%b exp=%b", obs_f, 9'b0101_000_0_0);
        end
    endtask

    task automatic test_basic();
        rstn = 1'b1;
        step(1);            // E0: HOLD -> LOCK_WAIT
        step(11);           // E11
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL basic_e11 got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(1);            // E12: stage 0 released
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL basic_e12 got=%b exp=%b", obs, 6'b11_01_0_0);
        end
        step(7);            // E19
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL basic_e19 got=%b exp=%b", obs, 6'b11_01_0_0);
        end
        step(1);            // E20: stage 1 released, RUN
        checks++;
        if (obs !== 6'b01_10_1_0) begin
            errors++; $display("FAIL basic_e20 got=%b exp=%b", obs, 6'b01_10_1_0);
        end
    endtask

    task automatic test_glitch();
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);            // E0
        step(1);            // E1
        pll_lock = 1'b0;
        step(1);            // E2 samples low
        pll_lock = 1'b1;
        step(11);           // E13: RELEASE was entered at E6
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL glitch_e13 got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(1);            // E14
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL glitch_e14 got=%b exp=%b", obs, 6'b11_01_0_0);
        end
    endtask

    task automatic test_lock_loss();
        step(8);            // E22: RUN
        checks++;
        if (obs !== 6'b01_10_1_0) begin
            errors++; $display("FAIL loss_run got=%b exp=%b", obs, 6'b01_10_1_0);
        end
        pll_lock = 1'b0;
        step(1);            // L0
        pll_lock = 1'b1;
        checks++;
        if (obs !== 6'b10_00_0_1) begin
            errors++; $display("FAIL loss_event got=%b exp=%b", obs, 6'b10_00_0_1);
        end
        step(12);           // L12
        checks++;
        if (obs !== 6'b11_01_0_1) begin
            errors++; $display("FAIL loss_reseq_s0 got=%b exp=%b", obs, 6'b11_01_0_1);
        end
        step(8);            // L20
        checks++;
        if (obs !== 6'b01_10_1_1) begin
            errors++; $display("FAIL loss_reseq_s1 got=%b exp=%b", obs, 6'b01_10_1_1);
        end
        pll_lock = 1'b0; lock_lost_clr = 1'b1;
        step(1);
        pll_lock = 1'b1;
        checks++;
        if (obs !== 6'b10_00_0_1) begin
            errors++; $display("FAIL loss_set_wins got=%b exp=%b", obs, 6'b10_00_0_1);
        end
        step(1);            // clr alone
        lock_lost_clr = 1'b0;
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL loss_clear got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        pll_lock = 1'b0;
        step(1);            // drop during LOCK_WAIT raises no flag
        pll_lock = 1'b1;
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL loss_in_wait got=%b exp=%b", obs, 6'b10_00_0_0);
        end
    endtask

    task automatic test_sw_rst();
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);            // E0
        step(12);           // E12
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL sw_pre got=%b exp=%b", obs, 6'b11_01_0_0);
        end
        sw_rst = 1'b1;
        step(1);            // S0
        sw_rst = 1'b0;
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL sw_event got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(11);           // S11
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL sw_s11 got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(1);            // S12
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL sw_s12 got=%b exp=%b", obs, 6'b11_01_0_0);
        end
    endtask

    task automatic test_reset_mid();
        step(8);            // S20: RUN
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        checks++;
        if (obs !== 6'b10_00_0_1) begin
            errors++; $display("FAIL mid_loss got=%b exp=%b", obs, 6'b10_00_0_1);
        end
        rstn = 1'b0;
        step(1);
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL mid_reset got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(20);
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL mid_hold got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        rstn = 1'b1;
        step(1);            // E0
        step(11);           // E11
        checks++;
        if (obs !== 6'b10_00_0_0) begin
            errors++; $display("FAIL mid_e11 got=%b exp=%b", obs, 6'b10_00_0_0);
        end
        step(1);            // E12
        checks++;
        if (obs !== 6'b11_01_0_0) begin
            errors++; $display("FAIL mid_e12 got=%b exp=%b", obs, 6'b11_01_0_0);
        end
    endtask

    // obs_f fields: {rst_out[3:0], stage_idx[2:0], seq_done, lock_lost}
    task automatic test_fast();
        pll_lock = 1'b1;
        rstn_f = 1'b1;
        step(1);            // E0: LOCK_WAIT
        step(1);            // E1: RELEASE
        checks++;
        if (obs_f !== 9'b0101_000_0_0) begin
            errors++; $display("FAIL fast_e1 got=%b exp=%b", obs_f, 9'b0101_000_0_0);
        end
        step(1);
        checks++;
        if (obs_f !== 9'b0100_001_0_0) begin
            errors++; $display("FAIL fast_e2 got=%b exp=%b", obs_f, 9'b0100_001_0_0);
        end
        step(1);
        checks++;
        if (obs_f !== 9'b0110_010_0_0) begin
            errors++; $display("FAIL fast_e3 got=%b exp=%b", obs_f, 9'b0110_010_0_0);
        end
        step(1);
        checks++;
        if (obs_f !== 9'b0010_011_0_0) begin
            errors++; $display("FAIL fast_e4 got=%b exp=%b", obs_f, 9'b0010_011_0_0);
        end
        step(1);
        checks++;
        if (obs_f !== 9'b1010_100_1_0) begin
            errors++; $display("FAIL fast_e5 got=%b exp=%b", obs_f, 9'b1010_100_1_0);
        end
        step(3);
        checks++;
        if (obs_f !== 9'b1010_100_1_0) begin
            errors++; $display("FAIL fast_hold got=%b exp=%b", obs_f, 9'b1010_100_1_0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_lock_loss();
        test_sw_rst();
        test_reset_mid();
        test_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and recovery reset sequencer for the ethernet subsystem. It generates NUM_STAGES reset outputs. Each output has its own polarity. Outputs are released in order, 0 first, one stage every STAGE_DELAY cycles, once the PLL lock has been stable for LOCK_FILTER cycles. Unlike the earlier single-shot scheme, it re-sequences on PLL lock loss or a software reset request, reports sticky lock-loss status, and has a fast simulation mode selected by parameter instead of a macro.

Parameters:
NUM_STAGES, 2, number of sequenced reset outputs (1..8); stage 0 is released first.
CNT_W, 20, width of the delay and filter counters; must hold max(STAGE_DELAY, LOCK_FILTER); elaboration error otherwise.
STAGE_DELAY, 20'h10000, cycles between successive stage releases.
LOCK_FILTER, 256, consecutive cycles pll_lock must be high before sequencing starts.
ACTIVE_LOW, 2'b01, per-stage polarity mask; bit k = 1 means rst_out[k] is asserted at 0.
SIM_FAST, 0, when 1, STAGE_DELAY and LOCK_FILTER are both treated as 1.

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
pll_lock  in  1  PLL lock indicator, already synchronous to clk
sw_rst  in  1  single-cycle soft reset request
lock_lost_clr  in  1  clears lock_lost
rst_out  out  NUM_STAGES  sequenced resets, per-stage polarity set by ACTIVE_LOW
stage_idx  out  $clog2(NUM_STAGES+1)  number of stages currently released
seq_done  out  1  high while all stages are released
lock_lost  out  1  sticky; PLL lock dropped after sequencing had started

Behaviour:
- "Asserted" for rst_out[k] means the value ~ACTIVE_LOW[k].
- Reset (rstn=0, sampled at posedge):
  - state HOLD; all rst_out asserted; stage_idx 0; seq_done 0; lock_lost 0; counters 0.
- HOLD:
  - all stages asserted.
  - the first edge with rstn=1 moves to LOCK_WAIT.
- LOCK_WAIT:
  - lock counter increments on each edge with pll_lock=1.
  - an edge with pll_lock=0 clears the lock counter; no flag is set.
  - on the LOCK_FILTER-th consecutive high edge: go to RELEASE, clear the delay counter.
- RELEASE:
  - delay counter increments every edge.
  - when it reaches STAGE_DELAY: de-assert stage stage_idx, increment stage_idx, clear the counter.
  - stage k is released exactly STAGE_DELAY*(k+1) edges after RELEASE entry.
  - the edge that releases the last stage also enters RUN and sets seq_done=1.
- RUN:
  - holds all stages released.
- Lock loss (pll_lock=0 sampled in RELEASE or RUN):
  - on the next edge, all rst_out re-assert; stage_idx 0; seq_done 0; lock_lost 1; go to LOCK_WAIT.
- sw_rst=1 in LOCK_WAIT, RELEASE or RUN:
  - same as lock loss, but lock_lost is unchanged.
  - the lock filter restarts from 0.
- sw_rst in HOLD is ignored.
- Priority: rstn low > lock loss > sw_rst > normal progression.
- lock_lost_clr and a lock-loss event on the same edge: set wins.
- Outputs are registered only; no combinational path from input to output.
- Counters never wrap: they are cleared on every state transition and on each stage release.
- Stage release order is strictly ascending; there is never more than one release per edge.

Decomposition:
- Header reset_seq_defs.vh holds:
  - state encodings HOLD=0, LOCK_WAIT=1, RELEASE=2, RUN=3;
  - the helper for effective delay under SIM_FAST.
- One natural sub-module: lock_filter.
  - Parameters CNT_W and LOCK_FILTER; inputs clk, rstn, enable, pll_lock; output locked_pulse.
  - Asserts locked_pulse for one cycle after N consecutive high samples.
  - Clears on enable=0 or pll_lock=0.

Test Plan:
1. Basic sequence. NUM_STAGES=2, STAGE_DELAY=8, LOCK_FILTER=4, pll_lock=1, rstn released at edge E0 -> LOCK_WAIT E0, RELEASE at E4, rst_out[0] (active-low) rises at E12, rst_out[1] (active-high) falls at E20, seq_done=1 at E20.
2. Glitchy lock. Same setup, pll_lock low for 1 cycle at E2 -> filter restarts; RELEASE entry delayed to 4 high edges after the glitch; no lock_lost.
3. Lock loss in RUN. Drop pll_lock for 1 cycle -> next edge: all stages asserted, seq_done=0, lock_lost=1; full re-sequence after relock; lock_lost stays 1 until lock_lost_clr. With clr and a new loss on the same edge, lock_lost=1.
4. sw_rst mid-RELEASE. Pulse sw_rst after stage 0 is released -> all re-asserted next edge, stage_idx=0, lock_lost=0, sequence restarts with correct timing.
5. Reset mid-operation. rstn=0 during RUN -> next edge all outputs at reset values; nothing releases until rstn=1 and the filter passes again.
6. SIM_FAST=1, NUM_STAGES=4, ACTIVE_LOW=4'b1010 -> RELEASE entered one edge after LOCK_WAIT; stages release on 4 consecutive edges with the correct per-bit polarity.
